// File: rtl/adc_sample_averager.sv
// Sequences ADC conversions on a fixed period, averages 2^LOG2_N captured samples
// and offers each average on a valid/ready stream with a sticky overrun flag.
module adc_sample_averager #(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned LOG2_N        = 2,
  parameter int unsigned CONV_CYCLES   = 10,
  parameter int unsigned SAMPLE_PERIOD = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic              adc_start,
  input  logic [DATA_W-1:0] adc_data,
  output logic [DATA_W-1:0] avg_data,
  output logic              avg_valid,
  input  logic              avg_ready,
  output logic              overrun
);

  localparam int unsigned ACC_W  = DATA_W + LOG2_N;
  localparam int unsigned CNT_W  = (LOG2_N > 0) ? LOG2_N : 1;
  localparam int unsigned TMR_W  = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned N_LAST = (1 << LOG2_N) - 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_CAPTURE,
    ST_GAP
  } state_e;

  state_e              state_q, state_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                adc_start_q, adc_start_d;
  logic [DATA_W-1:0]   avg_data_q, avg_data_d;
  logic                avg_valid_q, avg_valid_d;
  logic                overrun_q, overrun_d;
  logic [ACC_W-1:0]    sum;
  logic                period_end;
  logic                load;

  // Timer counts cycles since START entry; it paces both WAIT and GAP.
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q + TMR_W'(1);
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    avg_data_d  = avg_data_q;
    avg_valid_d = avg_valid_q;
    overrun_d   = overrun_q;
    load        = 1'b0;
    sum         = acc_q + ACC_W'(adc_data);
    period_end  = (tmr_q == TMR_W'(SAMPLE_PERIOD - 1));

    case (state_q)
      ST_IDLE: begin
        tmr_d = '0;
        if (enable) state_d = ST_START;
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (tmr_q == TMR_W'(CONV_CYCLES)) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // A zero-length gap (period == conv + 2) leaves CAPTURE straight for the next sample.
        state_d = ST_GAP;
        if (period_end) state_d = enable ? ST_START : ST_IDLE;
        if (cnt_q == CNT_W'(N_LAST)) begin
          avg_data_d = DATA_W'(sum >> LOG2_N);
          load       = 1'b1;
          acc_d      = '0;
          cnt_d      = '0;
        end else begin
          acc_d = sum;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (period_end) state_d = enable ? ST_START : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_START) tmr_d = '0;

    // Dropping back to IDLE discards any partial group.
    if (state_d == ST_IDLE) begin
      acc_d = '0;
      cnt_d = '0;
    end

    if (load) begin
      avg_valid_d = 1'b1;
      if (avg_valid_q && !avg_ready) overrun_d = 1'b1;
    end else if (avg_valid_q && avg_ready) begin
      avg_valid_d = 1'b0;
    end

    adc_start_d = (state_d == ST_START);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tmr_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      adc_start_q <= 1'b0;
      avg_data_q  <= '0;
      avg_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      adc_start_q <= adc_start_d;
      avg_data_q  <= avg_data_d;
      avg_valid_q <= avg_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign adc_start = adc_start_q;
  assign avg_data  = avg_data_q;
  assign avg_valid = avg_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_adc_sample_averager.sv
// Directed bench for adc_sample_averager: timing, arithmetic, back-pressure,
// enable drop and mid-conversion reset, with hand-computed expectations.
module tb_adc_sample_averager;

  localparam int unsigned DATA_W = 8;
  localparam int          CONV   = 10;
  localparam int          PERIOD = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic              adc_start;
  logic [DATA_W-1:0] adc_data;
  logic [DATA_W-1:0] avg_data;
  logic              avg_valid;
  logic              avg_ready;
  logic              overrun;

  int n_cmp = 0;
  int n_err = 0;
  int now   = 0;

  adc_sample_averager #(
    .DATA_W(DATA_W), .LOG2_N(2), .CONV_CYCLES(CONV), .SAMPLE_PERIOD(PERIOD)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .adc_start(adc_start),
    .adc_data(adc_data), .avg_data(avg_data), .avg_valid(avg_valid),
    .avg_ready(avg_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      now++;
    end
  endtask

  // Advance to the next adc_start pulse, bounded so a dead sequencer cannot hang the run.
  task automatic wait_start(input string tag, output int at);
    int guard;
    guard = 0;
    do begin
      tick();
      guard++;
    end while (adc_start !== 1'b1 && guard < 3 * PERIOD);
    check({tag, "_start_seen"}, 32'(adc_start), 32'd1);
    at = now;
  endtask

  task automatic feed(input logic [7:0] v, output int at);
    wait_start("feed", at);
    adc_data = v;
  endtask

  task automatic feed_group(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d, output int last);
    int t;
    feed(a, t);
    feed(b, t);
    feed(c, t);
    feed(d, last);
  endtask

  // Result from a group whose last START was at 'last' is visible at last+CONV+2.
  task automatic expect_result(input string tag, input int last, input logic [7:0] data);
    tick(last + CONV + 2 - now);
    check({tag, "_valid"}, 32'(avg_valid), 32'd1);
    check({tag, "_data"}, 32'(avg_data), 32'(data));
  endtask

  task automatic do_reset(input string tag, input int cycles);
    rst = 1'b1;
    tick(cycles);
    rst = 1'b0;
    check({tag, "_adc_start"}, 32'(adc_start), 32'd0);
    check({tag, "_avg_data"}, 32'(avg_data), 32'd0);
    check({tag, "_avg_valid"}, 32'(avg_valid), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    int t0, t1, e, last;
    logic saw;

    // Reset with arbitrary inputs, then idle with enable low.
    rst       = 1'b1;
    enable    = 1'b0;
    adc_data  = 8'($urandom);
    avg_ready = 1'($urandom);
    do_reset("rst", 2);
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      saw |= adc_start;
    end
    check("idle_no_start", 32'(saw), 32'd0);

    // Steady sampling at 0x80: start cadence and result latency.
    avg_ready = 1'b0;
    adc_data  = 8'h80;
    enable    = 1'b1;
    e         = now;
    wait_start("s0", t0);
    check("first_start_latency", 32'(t0 - e), 32'd1);
    for (int i = 1; i < 4; i++) begin
      wait_start("sn", t1);
      check("start_spacing", 32'(t1 - t0), 32'(PERIOD));
      t0 = t1;
    end
    tick(t0 + CONV + 1 - now);
    check("steady_valid_before", 32'(avg_valid), 32'd0);
    tick();
    check("steady_valid", 32'(avg_valid), 32'd1);
    check("steady_data", 32'(avg_data), 32'h80);
    avg_ready = 1'b1;
    tick();
    check("steady_drop", 32'(avg_valid), 32'd0);
    check("steady_overrun", 32'(overrun), 32'd0);

    // Arithmetic: truncation, full scale without wrap, zero.
    feed_group(8'd10, 8'd20, 8'd30, 8'd41, last);
    expect_result("arith_101", last, 8'h19);
    feed_group(8'hFF, 8'hFF, 8'hFF, 8'hFF, last);
    expect_result("arith_ff", last, 8'hFF);
    feed_group(8'h00, 8'h00, 8'h00, 8'h00, last);
    expect_result("arith_00", last, 8'h00);
    check("arith_overrun", 32'(overrun), 32'd0);

    // Back-pressure: unconsumed result overwritten sets overrun.
    avg_ready = 1'b0;
    do_reset("bp_rst", 1);
    feed_group(8'd1, 8'd1, 8'd1, 8'd1, last);
    expect_result("bp_first", last, 8'd1);
    check("bp_first_overrun", 32'(overrun), 32'd0);
    feed_group(8'd8, 8'd8, 8'd8, 8'd8, last);
    expect_result("bp_second", last, 8'd8);
    check("bp_overrun", 32'(overrun), 32'd1);

    // Ready asserted on the load cycle consumes the old result: no overrun.
    do_reset("bpr_rst", 1);
    feed_group(8'd4, 8'd4, 8'd4, 8'd4, last);
    expect_result("bpr_first", last, 8'd4);
    feed_group(8'd12, 8'd12, 8'd12, 8'd12, last);
    tick(last + CONV + 1 - now);
    avg_ready = 1'b1;
    tick();
    check("bpr_valid", 32'(avg_valid), 32'd1);
    check("bpr_data", 32'(avg_data), 32'd12);
    check("bpr_overrun", 32'(overrun), 32'd0);

    // Enable drop after the 2nd capture of a group; partial sum must be discarded.
    do_reset("en_rst", 1);
    feed(8'hF0, t0);
    feed(8'hF0, t1);
    tick(t1 + CONV + 2 - now);
    enable = 1'b0;
    saw    = 1'b0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      tick();
      saw |= adc_start;
    end
    check("en_no_start", 32'(saw), 32'd0);
    check("en_idle_valid", 32'(avg_valid), 32'd0);
    enable = 1'b1;
    feed_group(8'h10, 8'h10, 8'h10, 8'h10, last);
    tick(last + CONV + 1 - now);
    check("en_valid_before", 32'(avg_valid), 32'd0);
    expect_result("en_result", last, 8'h10);

    // Reset during WAIT of the 3rd sample; next average uses only fresh samples.
    feed(8'hFF, t0);
    feed(8'hFF, t0);
    feed(8'hFF, t0);
    tick(4);
    do_reset("mid_rst", 1);
    feed_group(8'h20, 8'h20, 8'h20, 8'h20, last);
    tick(last + CONV + 1 - now);
    check("mid_valid_before", 32'(avg_valid), 32'd0);
    expect_result("mid_result", last, 8'h20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
